// File: rtl/tetris_board_engine.sv
// Small Tetris board engine: alternating single/bar pieces, lateral moves, gravity and hard drop,
// lock into the stored board, then one full-row clear per cycle.
//   state    | meaning
//   SPAWN    | place next piece at top, or detect blocked spawn
//   FALL     | active piece: lateral moves, gravity or drop descent
//   LOCK     | merge piece into stored board
//   CLEAR    | remove lowest full row per cycle, then respawn
//   GAMEOVER | frozen until reset
module tetris_board_engine #(
  parameter int COLS     = 4,
  parameter int ROWS     = 8,
  parameter int GRAV_DIV = 4,
  parameter int SCORE_W  = 8
) (
  input  logic                 in_clk,
  input  logic                 in_restart_n,
  input  logic [1:0]           in_move,
  output logic [COLS*ROWS-1:0] board_out,
  output logic [SCORE_W-1:0]   out_score,
  output logic                 out_game_over,
  output logic                 out_piece_valid
);

  localparam int N         = COLS * ROWS;
  localparam int CW        = $clog2(COLS);
  localparam int RW        = $clog2(ROWS);
  localparam int GW        = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int SPAWN_COL = COLS / 2 - 1;

  typedef enum logic [2:0] {S_SPAWN, S_FALL, S_LOCK, S_CLEAR, S_GAMEOVER} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       board_q, board_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [GW-1:0]      grav_q, grav_d;
  logic               drop_q, drop_d;
  logic               bar_q, bar_d;
  logic               next_bar_q, next_bar_d;

  logic [CW-1:0]      c_lat;
  logic               grav_tc;
  logic               full_found;
  int                 full_row;
  logic [N-1:0]       board_shift;

  // Occupancy mask of a piece whose left cell sits at (r, c); a bar also covers c+1.
  function automatic logic [N-1:0] cells(input logic bar, input int r, input int c);
    logic [N-1:0] m;
    m = '0;
    m[COLS-1:0] = (bar ? COLS'(3) : COLS'(1)) << c;
    return m << (r * COLS);
  endfunction

  always_comb begin
    full_found  = 1'b0;
    full_row    = 0;
    board_shift = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (&board_q[r*COLS +: COLS]) begin
        full_found = 1'b1;
        full_row   = r;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (r > full_row)
        board_shift[r*COLS +: COLS] = board_q[r*COLS +: COLS];
      else if (r == 0)
        board_shift[r*COLS +: COLS] = '0;
      else
        board_shift[r*COLS +: COLS] = board_q[(r-1)*COLS +: COLS];
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    score_d    = score_q;
    row_d      = row_q;
    col_d      = col_q;
    grav_d     = grav_q;
    drop_d     = drop_q;
    bar_d      = bar_q;
    next_bar_d = next_bar_q;
    c_lat      = col_q;
    grav_tc    = (grav_q == GW'(GRAV_DIV - 1));
    case (state_q)
      S_SPAWN: begin
        grav_d     = '0;
        drop_d     = 1'b0;
        bar_d      = next_bar_q;
        next_bar_d = ~next_bar_q;
        row_d      = '0;
        col_d      = CW'(SPAWN_COL);
        if ((cells(next_bar_q, 0, SPAWN_COL) & board_q) != '0)
          state_d = S_GAMEOVER;
        else
          state_d = S_FALL;
      end
      S_FALL: begin
        drop_d = drop_q || (in_move == 2'd3);
        if (!drop_q) begin
          if (in_move == 2'd1 && col_q != '0 &&
              (cells(bar_q, int'(row_q), int'(col_q) - 1) & board_q) == '0)
            c_lat = col_q - 1'b1;
          else if (in_move == 2'd2 && int'(col_q) + int'(bar_q) < COLS - 1 &&
                   (cells(bar_q, int'(row_q), int'(col_q) + 1) & board_q) == '0)
            c_lat = col_q + 1'b1;
        end
        col_d  = c_lat;
        grav_d = grav_tc ? '0 : grav_q + 1'b1;
        // Descent is tried from the post-lateral column.
        if (drop_q || grav_tc) begin
          if (row_q == RW'(ROWS - 1) ||
              (cells(bar_q, int'(row_q) + 1, int'(c_lat)) & board_q) != '0)
            state_d = S_LOCK;
          else
            row_d = row_q + 1'b1;
        end
      end
      S_LOCK: begin
        board_d = board_q | cells(bar_q, int'(row_q), int'(col_q));
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (full_found) begin
          board_d = board_shift;
          if (score_q != '1)
            score_d = score_q + 1'b1;
        end else begin
          state_d = S_SPAWN;
        end
      end
      S_GAMEOVER: begin
        state_d = S_GAMEOVER;
      end
      default: state_d = S_SPAWN;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_restart_n) begin
    if (!in_restart_n) begin
      state_q    <= S_SPAWN;
      board_q    <= '0;
      score_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      grav_q     <= '0;
      drop_q     <= 1'b0;
      bar_q      <= 1'b0;
      next_bar_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      score_q    <= score_d;
      row_q      <= row_d;
      col_q      <= col_d;
      grav_q     <= grav_d;
      drop_q     <= drop_d;
      bar_q      <= bar_d;
      next_bar_q <= next_bar_d;
    end
  end

  assign out_piece_valid = (state_q == S_FALL);
  assign out_game_over   = (state_q == S_GAMEOVER);
  assign out_score       = score_q;
  assign board_out       = board_q | (out_piece_valid ? cells(bar_q, int'(row_q), int'(col_q)) : '0);

endmodule

// File: tb/tb_tetris_board_engine.sv
// Bench for tetris_board_engine: directed scenarios plus random moves against a row-array game model.
module tb_tetris_board_engine;
  localparam int COLS = 4, ROWS = 8, GRAV_DIV = 4, SCORE_W = 8;
  localparam int N = COLS * ROWS;
  localparam int PH_SPAWN = 0, PH_FALL = 1, PH_LOCK = 2, PH_CLEAR = 3, PH_OVER = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         move = 2'd0;
  logic [N-1:0]       board;
  logic [SCORE_W-1:0] score;
  logic               game_over, piece_valid;

  int vectors = 0;
  int miscompares = 0;

  logic [COLS-1:0] mb [ROWS];
  int ph, pr, pc, grav, score_m;
  bit pbar, next_bar, drop;

  always #5 clk = ~clk;

  tetris_board_engine #(.COLS(COLS), .ROWS(ROWS), .GRAV_DIV(GRAV_DIV), .SCORE_W(SCORE_W)) dut (
    .in_clk(clk), .in_restart_n(rst_n), .in_move(move),
    .board_out(board), .out_score(score), .out_game_over(game_over), .out_piece_valid(piece_valid)
  );

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++) mb[r] = '0;
    ph = PH_SPAWN; pr = 0; pc = 0; grav = 0; score_m = 0;
    pbar = 1'b0; next_bar = 1'b0; drop = 1'b0;
  endfunction

  function automatic bit fits(bit bar, int r, int c);
    if (r < 0 || r >= ROWS || c < 0 || c + int'(bar) >= COLS) return 1'b0;
    if (mb[r][c]) return 1'b0;
    if (bar && mb[r][c+1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(logic [1:0] mv);
    bit was_drop;
    int f;
    case (ph)
      PH_SPAWN: begin
        pbar = next_bar; next_bar = !next_bar;
        pr = 0; pc = COLS / 2 - 1; grav = 0; drop = 1'b0;
        ph = fits(pbar, pr, pc) ? PH_FALL : PH_OVER;
      end
      PH_FALL: begin
        was_drop = drop;
        if (mv == 2'd3) drop = 1'b1;
        if (!was_drop) begin
          if (mv == 2'd1 && fits(pbar, pr, pc - 1)) pc--;
          else if (mv == 2'd2 && fits(pbar, pr, pc + 1)) pc++;
        end
        if (was_drop || grav == GRAV_DIV - 1) begin
          if (fits(pbar, pr + 1, pc)) pr++;
          else ph = PH_LOCK;
        end
        grav = (grav == GRAV_DIV - 1) ? 0 : grav + 1;
      end
      PH_LOCK: begin
        mb[pr][pc] = 1'b1;
        if (pbar) mb[pr][pc+1] = 1'b1;
        ph = PH_CLEAR;
      end
      PH_CLEAR: begin
        f = -1;
        for (int r = ROWS - 1; r >= 0; r--)
          if (f < 0 && (&mb[r])) f = r;
        if (f >= 0) begin
          for (int i = f; i > 0; i--) mb[i] = mb[i-1];
          mb[0] = '0;
          if (score_m < 2**SCORE_W - 1) score_m++;
        end else begin
          ph = PH_SPAWN;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [N-1:0] exp_board();
    logic [N-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mb[r][c]) b[r*COLS + c] = 1'b1;
    if (ph == PH_FALL) begin
      b[pr*COLS + pc] = 1'b1;
      if (pbar) b[pr*COLS + pc + 1] = 1'b1;
    end
    return b;
  endfunction

  task automatic tick(input logic [1:0] mv);
    move = mv;
    @(posedge clk);
    if (rst_n) model_step(mv);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    move = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs idle cycles until the model has retired the current piece and holds a new one (or is over).
  task automatic advance();
    bit left;
    left = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(2'd0);
      if (ph != PH_FALL) left = 1'b1;
      if (left && (ph == PH_FALL || ph == PH_OVER)) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    move = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (board !== '0) begin miscompares++; $display("FAIL reset_board: got %h want 0", board); end
    vectors++; if (score !== '0) begin miscompares++; $display("FAIL reset_score: got %0d want 0", score); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    vectors++; if (piece_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", piece_valid); end
  endtask

  task automatic test_spawn_gravity();
    apply_reset();
    tick(2'd0);
    vectors++; if (board !== 32'h0000_0002) begin miscompares++; $display("FAIL spawn_board: got %h want 00000002", board); end
    vectors++; if (piece_valid !== 1'b1) begin miscompares++; $display("FAIL spawn_valid: got %b want 1", piece_valid); end
    for (int i = 0; i < 3; i++) begin
      tick(2'd0);
      vectors++; if (board !== exp_board()) begin miscompares++; $display("FAIL gravity_wait: cycle %0d got %h want %h", i, board, exp_board()); end
    end
    tick(2'd0);
    vectors++; if (board !== 32'h0000_0020) begin miscompares++; $display("FAIL gravity_step: got %h want 00000020", board); end
  endtask

  task automatic test_lateral_walls();
    apply_reset();
    tick(2'd0);
    repeat (3) tick(2'd1);
    vectors++; if (board !== 32'h0000_0001) begin miscompares++; $display("FAIL left_wall: got %h want 00000001", board); end
    repeat (4) tick(2'd2);
    vectors++; if (board !== 32'h0000_0080) begin miscompares++; $display("FAIL right_wall: got %h want 00000080", board); end
    vectors++; if (board !== exp_board()) begin miscompares++; $display("FAIL lateral_model: got %h want %h", board, exp_board()); end
  endtask

  task automatic test_hard_drop();
    apply_reset();
    tick(2'd0);
    tick(2'd3);
    vectors++; if (board !== 32'h0000_0002) begin miscompares++; $display("FAIL drop_arm: got %h want 00000002", board); end
    repeat (7) tick(2'd0);
    vectors++; if (board !== 32'h2000_0000) begin miscompares++; $display("FAIL drop_bottom: got %h want 20000000", board); end
    tick(2'd0);
    vectors++; if (piece_valid !== 1'b0) begin miscompares++; $display("FAIL lock_valid: got %b want 0", piece_valid); end
    tick(2'd0);
    vectors++; if (board !== 32'h2000_0000) begin miscompares++; $display("FAIL stored_board: got %h want 20000000", board); end
    repeat (2) tick(2'd0);
    vectors++; if (board !== 32'h2000_0006) begin miscompares++; $display("FAIL bar_spawn: got %h want 20000006", board); end
    vectors++; if (piece_valid !== 1'b1) begin miscompares++; $display("FAIL bar_valid: got %b want 1", piece_valid); end
  endtask

  task automatic test_line_clear();
    apply_reset();
    tick(2'd0);
    tick(2'd1); tick(2'd3); advance();
    vectors++; if (board !== 32'h1000_0006) begin miscompares++; $display("FAIL clear_p1: got %h want 10000006", board); end
    tick(2'd2);
    vectors++; if (board !== 32'h1000_000C) begin miscompares++; $display("FAIL clear_bar_right: got %h want 1000000c", board); end
    tick(2'd3); advance();
    vectors++; if (board !== 32'hD000_0002) begin miscompares++; $display("FAIL clear_p2: got %h want d0000002", board); end
    tick(2'd3); advance();
    vectors++; if (board !== 32'h0000_0006) begin miscompares++; $display("FAIL clear_board: got %h want 00000006", board); end
    vectors++; if (score !== 8'd1) begin miscompares++; $display("FAIL clear_score: got %0d want 1", score); end
  endtask

  task automatic test_game_over();
    apply_reset();
    tick(2'd0);
    for (int p = 0; p < 8; p++) begin
      tick(2'd3);
      advance();
    end
    vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL over_flag: got %b want 1", game_over); end
    vectors++; if (piece_valid !== 1'b0) begin miscompares++; $display("FAIL over_valid: got %b want 0", piece_valid); end
    vectors++; if (board !== 32'h2626_2626) begin miscompares++; $display("FAIL over_board: got %h want 26262626", board); end
    for (int i = 0; i < 12; i++) begin
      tick(2'($urandom_range(0, 3)));
      vectors++; if (board !== 32'h2626_2626) begin miscompares++; $display("FAIL over_frozen: cycle %0d got %h want 26262626", i, board); end
      vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL over_hold: cycle %0d got %b want 1", i, game_over); end
    end
  endtask

  task automatic test_reset_mid_clear();
    apply_reset();
    tick(2'd0);
    tick(2'd1); tick(2'd3); advance();
    tick(2'd2); tick(2'd3); advance();
    tick(2'd1); tick(2'd3); advance();
    tick(2'd2); tick(2'd3); advance();
    tick(2'd3);
    for (int i = 0; i < 40; i++) begin
      tick(2'd0);
      if (ph == PH_CLEAR && score_m == 1) break;
    end
    vectors++; if (board !== 32'hD000_0000) begin miscompares++; $display("FAIL midclear_board: got %h want d0000000", board); end
    vectors++; if (score !== 8'd1) begin miscompares++; $display("FAIL midclear_score: got %0d want 1", score); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++; if (board !== '0) begin miscompares++; $display("FAIL async_board: got %h want 0", board); end
    vectors++; if (score !== '0) begin miscompares++; $display("FAIL async_score: got %0d want 0", score); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL async_game_over: got %b want 0", game_over); end
    rst_n = 1'b1;
    tick(2'd0);
    vectors++; if (board !== 32'h0000_0002) begin miscompares++; $display("FAIL respawn: got %h want 00000002", board); end
  endtask

  task automatic test_random();
    int over_cnt;
    int r;
    logic [1:0] mv;
    over_cnt = 0;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 15);
      mv = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 14) ? 2'd2 : 2'd3;
      tick(mv);
      vectors++; if (board !== exp_board()) begin miscompares++; $display("FAIL rand_board: cycle %0d got %h want %h", i, board, exp_board()); end
      vectors++; if (score !== SCORE_W'(score_m)) begin miscompares++; $display("FAIL rand_score: cycle %0d got %0d want %0d", i, score, score_m); end
      vectors++; if (game_over !== (ph == PH_OVER)) begin miscompares++; $display("FAIL rand_over: cycle %0d got %b want %b", i, game_over, ph == PH_OVER); end
      vectors++; if (piece_valid !== (ph == PH_FALL)) begin miscompares++; $display("FAIL rand_valid: cycle %0d got %b want %b", i, piece_valid, ph == PH_FALL); end
      if (ph == PH_OVER) begin
        over_cnt++;
        if (over_cnt > 3) begin
          apply_reset();
          over_cnt = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spawn_gravity();
    test_lateral_walls();
    test_hard_drop();
    test_line_clear();
    test_game_over();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
